receptor_2de5: RTL and testbench

Serial front end for the 2-of-5 display path. Assembles five serially received bits into one code word, checks that exactly two bits are set, and presents the last valid word on E1–E5 to the per-segment decoders (SegmentoA…SegmentoG) downstream. Invalid or incomplete frames are counted and reported, and never reach the decoders.

---
 rtl/receptor_2de5.sv | 154 +++++++++++++++
 tb/tb_receptor_2de5.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/receptor_2de5.sv
// receptor_2de5: serial 2-of-5 code word receiver.
// Collects five bits strobed by bit_en. A frame with exactly two ones is
// presented on E1..E5; any other weight is reported as an error. A partial
// frame that stalls for TIMEOUT clocks is discarded and reported as an abort.
module receptor_2de5 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  input  logic       bit_en,
  input  logic       clear,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       E5,
  output logic       code_valid,
  output logic       word_done,
  output logic       code_error,
  output logic       frame_abort,
  output logic [7:0] err_count
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      bits_q, bits_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [4:0]      word_q, word_d;      // word_q[0] = E1 (first bit received)
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            cerr_q, cerr_d;
  logic            abort_q, abort_d;
  logic [7:0]      err_q, err_d;
  logic [2:0]      weight;
  logic            bump_err;

  // Weight of the candidate word: four held bits plus the bit arriving now.
  always_comb begin
    weight = 3'(serial_in) + 3'(bits_q[0]) + 3'(bits_q[1])
           + 3'(bits_q[2]) + 3'(bits_q[3]);
  end

  // Next-state: frame assembly, code check, idle timeout and error counting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    timer_d  = timer_q;
    word_d   = word_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    cerr_d   = 1'b0;
    abort_d  = 1'b0;
    err_d    = err_q;
    bump_err = 1'b0;
    if (clear) begin
      // A bit_en coinciding with clear is dropped along with the frame.
      state_d = IDLE;
      cnt_d   = '0;
      bits_d  = '0;
      timer_d = '0;
      word_d  = '0;
      valid_d = 1'b0;
      err_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
          if (bit_en) begin
            bits_d[0] = serial_in;
            cnt_d     = 3'd1;
            state_d   = RECV;
          end
        end
        RECV: begin
          if (bit_en) begin
            timer_d = '0;
            if (cnt_q < 3'd4) begin
              bits_d[cnt_q[1:0]] = serial_in;
              cnt_d              = cnt_q + 3'd1;
            end else begin
              if (weight == 3'd2) begin
                word_d  = {serial_in, bits_q};
                valid_d = 1'b1;
                done_d  = 1'b1;
              end else begin
                cerr_d   = 1'b1;
                bump_err = 1'b1;
              end
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else if (timer_q == TMO_LAST) begin
            // TIMEOUT consecutive idle clocks since the last bit.
            abort_d  = 1'b1;
            bump_err = 1'b1;
            cnt_d    = '0;
            timer_d  = '0;
            state_d  = IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      if (bump_err && err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      timer_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cerr_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      timer_q <= timer_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cerr_q  <= cerr_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign E1          = word_q[0];
  assign E2          = word_q[1];
  assign E3          = word_q[2];
  assign E4          = word_q[3];
  assign E5          = word_q[4];
  assign code_valid  = valid_q;
  assign word_done   = done_q;
  assign code_error  = cerr_q;
  assign frame_abort = abort_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_receptor_2de5.sv
// Bench for receptor_2de5 (TIMEOUT=4): table of per-clock vectors with
// hand-computed expected outputs, plus a long error-saturation sequence.
module tb_receptor_2de5;

  logic       clk = 1'b0;
  logic       rst_n, serial_in, bit_en, clear;
  logic       E1, E2, E3, E4, E5;
  logic       code_valid, word_done, code_error, frame_abort;
  logic [7:0] err_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  receptor_2de5 #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .bit_en(bit_en),
    .clear(clear), .E1(E1), .E2(E2), .E3(E3), .E4(E4), .E5(E5),
    .code_valid(code_valid), .word_done(word_done), .code_error(code_error),
    .frame_abort(frame_abort), .err_count(err_count)
  );

  // e is written in E1..E5 order: 5'b10001 means E1=1, E5=1.
  typedef struct {
    logic       rst_n, clear, en, s;
    logic [4:0] e;
    logic       v, wd, ce, fa;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, c, en, s, input logic [4:0] e,
                              input logic v, wd, ce, fa, input int err);
    vec_t t;
    t.rst_n = r; t.clear = c; t.en = en; t.s = s; t.e = e;
    t.v = v; t.wd = wd; t.ce = ce; t.fa = fa; t.err = 8'(err);
    vecs.push_back(t);
  endfunction

  function automatic logic [4:0] ew();
    return {E1, E2, E3, E4, E5};
  endfunction

  task automatic step(input logic r, c, en, s);
    rst_n = r; clear = c; bit_en = en; serial_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    int ce_cnt, wd_cnt, multi;
    rst_n = 1'b0; clear = 1'b0; bit_en = 1'b0; serial_in = 1'b0;

    // reset with bit_en toggling
    add(0,0,1,1, 5'b00000, 0,0,0,0, 0);
    add(0,0,0,0, 5'b00000, 0,0,0,0, 0);
    // 1,0,0,0,1 -> valid
    add(1,0,1,1, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,1, 5'b10001, 1,1,0,0, 0);
    // back-to-back 0,1,1,0,0
    add(1,0,1,0, 5'b10001, 1,0,0,0, 0);
    add(1,0,1,1, 5'b10001, 1,0,0,0, 0);
    add(1,0,1,1, 5'b10001, 1,0,0,0, 0);
    add(1,0,1,0, 5'b10001, 1,0,0,0, 0);
    add(1,0,1,0, 5'b01100, 1,1,0,0, 0);
    // 1,1,1,0,0 -> weight 3, error, word held
    add(1,0,1,1, 5'b01100, 1,0,0,0, 0);
    add(1,0,1,1, 5'b01100, 1,0,0,0, 0);
    add(1,0,1,1, 5'b01100, 1,0,0,0, 0);
    add(1,0,1,0, 5'b01100, 1,0,0,0, 0);
    add(1,0,1,0, 5'b01100, 1,0,1,0, 1);
    // two bits then idle: abort exactly 4 clocks after the second bit
    add(1,0,1,1, 5'b01100, 1,0,0,0, 1);
    add(1,0,1,0, 5'b01100, 1,0,0,0, 1);
    add(1,0,0,0, 5'b01100, 1,0,0,0, 1);
    add(1,0,0,0, 5'b01100, 1,0,0,0, 1);
    add(1,0,0,0, 5'b01100, 1,0,0,0, 1);
    add(1,0,0,0, 5'b01100, 1,0,0,1, 2);
    add(1,0,0,0, 5'b01100, 1,0,0,0, 2);
    // then a valid 0,0,1,1,0
    add(1,0,1,0, 5'b01100, 1,0,0,0, 2);
    add(1,0,1,0, 5'b01100, 1,0,0,0, 2);
    add(1,0,1,1, 5'b01100, 1,0,0,0, 2);
    add(1,0,1,1, 5'b01100, 1,0,0,0, 2);
    add(1,0,1,0, 5'b00110, 1,1,0,0, 2);
    // a mid-frame bit restarts the idle timer
    add(1,0,1,1, 5'b00110, 1,0,0,0, 2);
    add(1,0,0,0, 5'b00110, 1,0,0,0, 2);
    add(1,0,0,0, 5'b00110, 1,0,0,0, 2);
    add(1,0,0,0, 5'b00110, 1,0,0,0, 2);
    add(1,0,1,0, 5'b00110, 1,0,0,0, 2);
    add(1,0,0,0, 5'b00110, 1,0,0,0, 2);
    add(1,0,0,0, 5'b00110, 1,0,0,0, 2);
    add(1,0,0,0, 5'b00110, 1,0,0,0, 2);
    add(1,0,0,0, 5'b00110, 1,0,0,1, 3);
    // three bits, clear (with a bit_en that is dropped), idle: no abort
    add(1,0,1,1, 5'b00110, 1,0,0,0, 3);
    add(1,0,1,0, 5'b00110, 1,0,0,0, 3);
    add(1,0,1,1, 5'b00110, 1,0,0,0, 3);
    add(1,1,1,1, 5'b00000, 0,0,0,0, 0);
    add(1,0,0,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,0,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,0,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,0,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,0,0, 5'b00000, 0,0,0,0, 0);
    // next frame 1,1,0,0,0 latched cleanly
    add(1,0,1,1, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,1, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,0, 5'b11000, 1,1,0,0, 0);
    // reset mid-frame: drops the partial frame, no abort afterwards
    add(1,0,1,1, 5'b11000, 1,0,0,0, 0);
    add(1,0,1,1, 5'b11000, 1,0,0,0, 0);
    add(0,0,1,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,0,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,0,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,0,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,0,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,0,0, 5'b00000, 0,0,0,0, 0);
    // reload a valid word 1,1,0,0,0 for the saturation run
    add(1,0,1,1, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,1, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,0, 5'b00000, 0,0,0,0, 0);
    add(1,0,1,0, 5'b11000, 1,1,0,0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].clear, vecs[i].en, vecs[i].s);
      check($sformatf("vec%0d", i),
            {15'd0, ew(), code_valid, word_done, code_error, frame_abort, err_count},
            {15'd0, vecs[i].e, vecs[i].v, vecs[i].wd, vecs[i].ce, vecs[i].fa, vecs[i].err});
    end

    // 300 all-zero frames with bit_en held high
    ce_cnt = 0; wd_cnt = 0; multi = 0;
    for (int f = 0; f < 300; f++) begin
      for (int b = 0; b < 5; b++) begin
        step(1, 0, 1, 0);
        if (code_error) ce_cnt++;
        if (word_done) wd_cnt++;
        if (int'(word_done) + int'(code_error) + int'(frame_abort) > 1) multi++;
      end
      if (f == 9) check("err_after_10", {24'd0, err_count}, 32'd10);
    end
    check("sat_err_count", {24'd0, err_count}, 32'd255);
    check("sat_ce_pulses", ce_cnt, 300);
    check("sat_wd_pulses", wd_cnt, 0);
    check("sat_onehot", multi, 0);
    check("sat_word_held", {27'd0, ew()}, {27'd0, 5'b11000});
    check("sat_valid", {31'd0, code_valid}, 32'd1);
    step(1, 0, 0, 0);
    check("sat_pulse_end", {29'd0, word_done, code_error, frame_abort}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
